// File: rtl/sha256_msg_padder_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared constants, state encodings and small helpers for the SHA-256
// message padder. The padder imports this package with import sha256_pkg::*.
//   SHA_BLOCK_WORDS : words per 512-bit block
//   LEN_HI_IDX      : word index carrying bit-length [63:32]
//   LEN_LO_IDX      : word index carrying bit-length [31:0]
//   PAD_WORD        : 0x80 terminator when it starts a fresh word
//   PAD_BYTE        : 0x80 terminator when it shares a word with message bytes
// ---------------------------------------------------------------------------
package sha256_pkg;

  localparam int         SHA_BLOCK_WORDS = 16;
  localparam logic [3:0] LEN_HI_IDX      = 4'(SHA_BLOCK_WORDS - 2);
  localparam logic [3:0] LEN_LO_IDX      = 4'(SHA_BLOCK_WORDS - 1);
  localparam logic [31:0] PAD_WORD       = 32'h8000_0000;
  localparam logic [7:0]  PAD_BYTE       = 8'h80;

  // Padder FSM encodings, kept as plain constants for legacy compatibility
  typedef logic [2:0] state_t;
  localparam state_t ST_DATA   = 3'd0;
  localparam state_t ST_PAD80  = 3'd1;
  localparam state_t ST_ZERO   = 3'd2;
  localparam state_t ST_LEN_HI = 3'd3;
  localparam state_t ST_LEN_LO = 3'd4;

  // Place a byte into a 32-bit word at big-endian lane pos (0 = bits [31:24])
  function automatic logic [31:0] place_byte(input logic [7:0] b, input logic [1:0] pos);
    return {b, 24'h00_0000} >> {pos, 3'b000};
  endfunction

  // After emitting the word at index idx during padding: if the length pair is
  // next, go write it; otherwise keep zero filling (possibly into a new block).
  function automatic state_t next_fill_state(input logic [3:0] idx);
    return ((idx + 4'd1) == LEN_HI_IDX) ? ST_LEN_HI : ST_ZERO;
  endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// sha256_msg_padder
// Packs a byte stream big-endian into 32-bit words and appends SHA-256
// padding (0x80, zero fill, 64-bit bit length), emitting 16-word blocks over
// a valid/ready word interface with a single output register.
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   in_data/in_valid/
//   in_last/in_ready     byte input stream, in_last marks the final byte
//   out_word/out_valid/
//   out_ready            padded word output (first byte in [31:24])
//   out_idx              word index within the block, 0..15
//   out_block_last       word 15 of any block
//   out_msg_last         word 15 of the final block of the message
//   err_overflow         sticky byte-counter wrap flag, cleared when the
//                        message's final word is consumed
// ---------------------------------------------------------------------------
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_idx,
  output logic        out_block_last,
  output logic        out_msg_last,
  output logic        err_overflow
);

  state_t            state, state_nxt;
  logic              run;
  logic [LEN_W-1:0]  byte_cnt, cnt_base, cnt_nxt;
  logic              err_base, err_nxt;
  logic [3:0]        wc;
  logic [1:0]        bc, bc_nxt;
  logic [31:0]       acc, acc_nxt, packed_word, load_word;
  logic              load, can_load, accept, msg_done;
  logic [63:0]       bit_len;

  // run holds in_ready low until the first clock after reset release
  assign can_load    = !out_valid || out_ready;
  assign in_ready    = run && (state == ST_DATA) && can_load;
  assign accept      = in_valid && in_ready;
  assign packed_word = acc | place_byte(in_data, bc);
  assign bit_len     = {{(61-LEN_W){1'b0}}, byte_cnt, 3'b000};

  // When the final length word is consumed, the next message may already be
  // accepting its first byte in the same cycle, so it counts from zero.
  assign msg_done = out_valid && out_ready && out_msg_last;
  assign cnt_base = msg_done ? '0 : byte_cnt;
  assign err_base = msg_done ? 1'b0 : err_overflow;

  // Next-state and word-load selection
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_word = '0;
    acc_nxt   = acc;
    bc_nxt    = bc;
    cnt_nxt   = cnt_base;
    err_nxt   = err_base;
    case (state)
      ST_DATA: begin
        if (accept) begin
          cnt_nxt = cnt_base + LEN_W'(1);
          if (&cnt_base) err_nxt = 1'b1;
          if (in_last || bc == 2'd3) begin
            load    = 1'b1;
            acc_nxt = '0;
            bc_nxt  = '0;
            if (bc == 2'd3) begin
              load_word = packed_word;
              if (in_last) state_nxt = ST_PAD80;
            end else begin
              // Short final word carries the terminator in the next lane
              load_word = packed_word | place_byte(PAD_BYTE, bc + 2'd1);
              state_nxt = next_fill_state(wc);
            end
          end else begin
            acc_nxt = packed_word;
            bc_nxt  = bc + 2'd1;
          end
        end
      end
      ST_PAD80: begin
        if (can_load) begin
          load      = 1'b1;
          load_word = PAD_WORD;
          state_nxt = next_fill_state(wc);
        end
      end
      ST_ZERO: begin
        if (can_load) begin
          load      = 1'b1;
          load_word = '0;
          state_nxt = next_fill_state(wc);
        end
      end
      ST_LEN_HI: begin
        if (can_load) begin
          load      = 1'b1;
          load_word = bit_len[63:32];
          state_nxt = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (can_load) begin
          load      = 1'b1;
          load_word = bit_len[31:0];
          state_nxt = ST_DATA;
        end
      end
      default: state_nxt = ST_DATA;
    endcase
  end

  // State, packer and output register. wc is the index the next loaded word
  // will carry; it wraps 15->0 so it is back at 0 after the length word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_DATA;
      run            <= 1'b0;
      byte_cnt       <= '0;
      err_overflow   <= 1'b0;
      wc             <= '0;
      bc             <= '0;
      acc            <= '0;
      out_word       <= '0;
      out_valid      <= 1'b0;
      out_idx        <= '0;
      out_block_last <= 1'b0;
      out_msg_last   <= 1'b0;
    end else begin
      run          <= 1'b1;
      state        <= state_nxt;
      byte_cnt     <= cnt_nxt;
      err_overflow <= err_nxt;
      bc           <= bc_nxt;
      acc          <= acc_nxt;
      if (load) begin
        out_word       <= load_word;
        out_valid      <= 1'b1;
        out_idx        <= wc;
        out_block_last <= (wc == LEN_LO_IDX);
        out_msg_last   <= (state == ST_LEN_LO);
        wc             <= wc + 4'd1;
      end else if (out_ready) begin
        out_valid      <= 1'b0;
        out_block_last <= 1'b0;
        out_msg_last   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_padder
// Directed bench for sha256_msg_padder. Two instances share the input stream:
// u_dut (LEN_W=32) for the main checks and u_dut8 (LEN_W=8) for counter wrap.
// ---------------------------------------------------------------------------
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_block_last, out_msg_last, err_overflow;
  logic [31:0] out_word;
  logic [3:0]  out_idx;
  logic        in_ready_8, out_valid_8, out_block_last_8, out_msg_last_8, err_overflow_8;
  logic [31:0] out_word_8;
  logic [3:0]  out_idx_8;

  int checks = 0;
  int failures = 0;
  bit stall_mode = 1'b0;

  logic [7:0]  msg_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] w32_q[$];
  logic [31:0] w8_q[$];
  logic [3:0]  idx_q[$];
  bit          bl_q[$];
  bit          ml_q[$];
  bit          err8_q[$];

  int          stall_seen = 0;
  int          stall_viol = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] held_word;
  logic [3:0]  held_idx;

  sha256_msg_padder #(.LEN_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_block_last(out_block_last), .out_msg_last(out_msg_last),
    .err_overflow(err_overflow)
  );

  sha256_msg_padder #(.LEN_W(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_8),
    .out_word(out_word_8), .out_valid(out_valid_8), .out_ready(out_ready),
    .out_idx(out_idx_8), .out_block_last(out_block_last_8), .out_msg_last(out_msg_last_8),
    .err_overflow(err_overflow_8)
  );

  always #5 clk = ~clk;

  // Consumer back-pressure, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Record every word that will handshake on the coming edge, and watch that
  // a stalled word stays put until it is taken
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_word !== held_word || out_idx !== held_idx))
        stall_viol++;
      if (out_valid && out_ready) begin
        w32_q.push_back(out_word);
        idx_q.push_back(out_idx);
        bl_q.push_back(out_block_last);
        ml_q.push_back(out_msg_last);
      end
      if (out_valid_8 && out_ready) begin
        w8_q.push_back(out_word_8);
        err8_q.push_back(err_overflow_8);
      end
      prev_stall = out_valid && !out_ready;
      held_word  = out_word;
      held_idx   = out_idx;
      if (prev_stall) stall_seen++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    w32_q.delete(); w8_q.delete(); idx_q.delete();
    bl_q.delete(); ml_q.delete(); err8_q.delete();
  endtask

  // Send msg_q[lo..hi]; must be called just after a rising edge
  task automatic send_range(input int lo, input int hi, input bit last_at_hi);
    bit accepted;
    int cyc;
    for (int i = lo; i <= hi; i++) begin
      in_data  = msg_q[i];
      in_valid = 1'b1;
      in_last  = last_at_hi && (i == hi);
      accepted = 1'b0;
      cyc      = 0;
      while (!accepted && cyc < 100) begin
        @(negedge clk);
        accepted = in_ready;
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!accepted) begin
        checks++; failures++;
        $display("[TB] FAIL send_timeout byte=%0d got=not_accepted exp=accepted", i);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_words(input int n, input bit use8);
    int cyc = 0;
    while (((use8 ? w8_q.size() : w32_q.size()) < n) && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    if (cyc >= 3000) begin
      checks++; failures++;
      $display("[TB] FAIL word_timeout got=%0d exp=%0d", use8 ? w8_q.size() : w32_q.size(), n);
    end
  endtask

  // Reference padding of msg_q: 0x80, zeros to 56 mod 64, 64-bit bit length
  // of the byte count taken modulo 2**len_w
  task automatic build_expected(input int len_w);
    logic [7:0]      p[$];
    longint unsigned cnt;
    longint unsigned bits;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    cnt  = longint'(msg_q.size()) % (64'd1 << len_w);
    bits = cnt * 8;
    for (int k = 7; k >= 0; k--) p.push_back(8'(bits >> (8 * k)));
    exp_q.delete();
    for (int i = 0; i < p.size(); i += 4) exp_q.push_back({p[i], p[i+1], p[i+2], p[i+3]});
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++;
    if (out_word !== 32'h0) begin failures++; $display("[TB] FAIL reset_out_word got=%h exp=0", out_word); end
    checks++;
    if ({out_idx, out_block_last, out_msg_last, err_overflow} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_markers got=%b exp=0000000", {out_idx, out_block_last, out_msg_last, err_overflow});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL release_in_ready_early got=%b exp=0", in_ready); end
    sync();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_abc();
    int n = 16;
    clear_queues();
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_range(0, 2, 1'b1);
    wait_words(n, 1'b0);
    repeat (4) sync();
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(i == 0 ? 32'h6162_6380 : (i == 15 ? 32'h0000_0018 : 32'h0));
    checks++;
    if (w32_q.size() != n) begin failures++; $display("[TB] FAIL abc_count got=%0d exp=%0d", w32_q.size(), n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (i >= w32_q.size()) begin
        failures++; $display("[TB] FAIL abc_word[%0d] got=missing exp=%h", i, exp_q[i]);
      end else if ({w32_q[i], idx_q[i], bl_q[i], ml_q[i]} !== {exp_q[i], 4'(i), i == 15, i == 15}) begin
        failures++;
        $display("[TB] FAIL abc_word[%0d] got=%h/%0d/%b/%b exp=%h/%0d/%b/%b", i,
                 w32_q[i], idx_q[i], bl_q[i], ml_q[i], exp_q[i], i, i == 15, i == 15);
      end
    end
  endtask

  task automatic test_55_bytes();
    int n = 16;
    clear_queues();
    msg_q.delete();
    for (int i = 0; i < 55; i++) msg_q.push_back(8'(i));
    build_expected(32);
    send_range(0, 54, 1'b1);
    wait_words(n, 1'b0);
    repeat (4) sync();
    checks++;
    if (w32_q.size() != n) begin failures++; $display("[TB] FAIL b55_count got=%0d exp=%0d", w32_q.size(), n); end
    for (int i = 0; i < n && i < w32_q.size(); i++) begin
      checks++;
      if ({w32_q[i], idx_q[i], bl_q[i], ml_q[i]} !== {exp_q[i], 4'(i), i == 15, i == 15}) begin
        failures++;
        $display("[TB] FAIL b55_word[%0d] got=%h/%0d/%b/%b exp=%h", i, w32_q[i], idx_q[i], bl_q[i], ml_q[i], exp_q[i]);
      end
    end
    checks++;
    if (w32_q[13] !== 32'h3435_3680) begin failures++; $display("[TB] FAIL b55_idx13 got=%h exp=34353680", w32_q[13]); end
    checks++;
    if (w32_q[15] !== 32'h0000_01B8) begin failures++; $display("[TB] FAIL b55_len got=%h exp=000001b8", w32_q[15]); end
  endtask

  task automatic test_56_bytes();
    int n = 32;
    int bl_cnt = 0;
    int ml_cnt = 0;
    clear_queues();
    msg_q.delete();
    for (int i = 0; i < 56; i++) msg_q.push_back(8'(8'hA0 + i));
    build_expected(32);
    send_range(0, 55, 1'b1);
    wait_words(n, 1'b0);
    repeat (4) sync();
    checks++;
    if (w32_q.size() != n) begin failures++; $display("[TB] FAIL b56_count got=%0d exp=%0d", w32_q.size(), n); end
    for (int i = 0; i < n && i < w32_q.size(); i++) begin
      bl_cnt += int'(bl_q[i]);
      ml_cnt += int'(ml_q[i]);
      checks++;
      if ({w32_q[i], idx_q[i], bl_q[i], ml_q[i]} !== {exp_q[i], 4'(i % 16), i % 16 == 15, i == n - 1}) begin
        failures++;
        $display("[TB] FAIL b56_word[%0d] got=%h/%0d/%b/%b exp=%h", i, w32_q[i], idx_q[i], bl_q[i], ml_q[i], exp_q[i]);
      end
    end
    checks++;
    if (w32_q[14] !== 32'h8000_0000) begin failures++; $display("[TB] FAIL b56_pad got=%h exp=80000000", w32_q[14]); end
    checks++;
    if (w32_q[15] !== 32'h0) begin failures++; $display("[TB] FAIL b56_idx15 got=%h exp=00000000", w32_q[15]); end
    checks++;
    if (w32_q[31] !== 32'h0000_01C0) begin failures++; $display("[TB] FAIL b56_len got=%h exp=000001c0", w32_q[31]); end
    checks++;
    if (bl_cnt != 2 || ml_cnt != 1) begin
      failures++; $display("[TB] FAIL b56_markers got=bl%0d/ml%0d exp=bl2/ml1", bl_cnt, ml_cnt);
    end
  endtask

  task automatic test_random_stall();
    int n = 32;
    clear_queues();
    stall_seen = 0;
    stall_viol = 0;
    msg_q.delete();
    for (int i = 0; i < 64; i++) msg_q.push_back(8'(i * 3 + 7));
    build_expected(32);
    stall_mode = 1'b1;
    send_range(0, 63, 1'b1);
    wait_words(n, 1'b0);
    stall_mode = 1'b0;
    repeat (4) sync();
    checks++;
    if (w32_q.size() != n) begin failures++; $display("[TB] FAIL stall_count got=%0d exp=%0d", w32_q.size(), n); end
    for (int i = 0; i < n && i < w32_q.size(); i++) begin
      checks++;
      if ({w32_q[i], idx_q[i], bl_q[i], ml_q[i]} !== {exp_q[i], 4'(i % 16), i % 16 == 15, i == n - 1}) begin
        failures++;
        $display("[TB] FAIL stall_word[%0d] got=%h/%0d/%b/%b exp=%h", i, w32_q[i], idx_q[i], bl_q[i], ml_q[i], exp_q[i]);
      end
    end
    checks++;
    if (w32_q[16] !== 32'h8000_0000) begin failures++; $display("[TB] FAIL stall_pad got=%h exp=80000000", w32_q[16]); end
    checks++;
    if (w32_q[31] !== 32'h0000_0200) begin failures++; $display("[TB] FAIL stall_len got=%h exp=00000200", w32_q[31]); end
    checks++;
    if (stall_viol != 0) begin failures++; $display("[TB] FAIL stall_stable got=%0d exp=0", stall_viol); end
    checks++;
    if (stall_seen == 0) begin failures++; $display("[TB] FAIL stall_exercised got=0 exp=nonzero"); end
  endtask

  task automatic test_reset_mid_message();
    int n = 16;
    msg_q.delete();
    for (int i = 0; i < 20; i++) msg_q.push_back(8'(8'h30 + i));
    send_range(0, 19, 1'b0);
    rst = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL midrst_in_ready got=%b exp=0", in_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sync();
    clear_queues();
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_range(0, 2, 1'b1);
    wait_words(n, 1'b0);
    repeat (6) sync();
    checks++;
    if (w32_q.size() != n) begin failures++; $display("[TB] FAIL midrst_count got=%0d exp=%0d", w32_q.size(), n); end
    for (int i = 0; i < n && i < w32_q.size(); i++) begin
      checks++;
      if ({w32_q[i], idx_q[i], ml_q[i]} !==
          {(i == 0 ? 32'h6162_6380 : (i == 15 ? 32'h0000_0018 : 32'h0)), 4'(i), i == 15}) begin
        failures++;
        $display("[TB] FAIL midrst_word[%0d] got=%h/%0d/%b", i, w32_q[i], idx_q[i], ml_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int n = 80;
    clear_queues();
    msg_q.delete();
    for (int i = 0; i < 256; i++) msg_q.push_back(8'(i));
    build_expected(8);
    send_range(0, 254, 1'b0);
    checks++;
    if (err_overflow_8 !== 1'b0) begin failures++; $display("[TB] FAIL ovf_before got=%b exp=0", err_overflow_8); end
    send_range(255, 255, 1'b1);
    checks++;
    if (err_overflow_8 !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set got=%b exp=1", err_overflow_8); end
    checks++;
    if (err_overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_wide got=%b exp=0", err_overflow); end
    wait_words(n, 1'b1);
    repeat (4) sync();
    checks++;
    if (w8_q.size() != n) begin failures++; $display("[TB] FAIL ovf_count got=%0d exp=%0d", w8_q.size(), n); end
    for (int i = 0; i < n && i < w8_q.size(); i++) begin
      checks++;
      if (w8_q[i] !== exp_q[i]) begin
        failures++; $display("[TB] FAIL ovf_word[%0d] got=%h exp=%h", i, w8_q[i], exp_q[i]);
      end
    end
    checks++;
    if (w8_q[64] !== 32'h8000_0000 || w8_q[78] !== 32'h0 || w8_q[79] !== 32'h0) begin
      failures++; $display("[TB] FAIL ovf_len got=%h/%h/%h exp=80000000/0/0", w8_q[64], w8_q[78], w8_q[79]);
    end
    checks++;
    if (err8_q[79] !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky got=%b exp=1", err8_q[79]); end
    checks++;
    if (w32_q.size() != n || w32_q[79] !== 32'h0000_0800) begin
      failures++; $display("[TB] FAIL wide_len got=%h exp=00000800", w32_q[79]);
    end
    clear_queues();
    msg_q = '{8'h5A};
    send_range(0, 0, 1'b1);
    checks++;
    if (err_overflow_8 !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear got=%b exp=0", err_overflow_8); end
    wait_words(16, 1'b1);
    repeat (4) sync();
    checks++;
    if (w8_q[0] !== 32'h5A80_0000 || w8_q[15] !== 32'h0000_0008) begin
      failures++; $display("[TB] FAIL ovf_next got=%h/%h exp=5a800000/00000008", w8_q[0], w8_q[15]);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_55_bytes();
    test_56_bytes();
    test_random_stall();
    test_reset_mid_message();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
